i2cmb_cmd_scheduler: RTL and testbench
======================================

# i2cmb_cmd_scheduler

Parametrised multi-channel command scheduler in front of the I2CMB byte-level engine. It queues byte-level commands from NUM_CH independent requesters in per-channel FIFOs and issues them one at a time to the single engine. Each channel owns I2C bus index equal to its channel number, and the block inserts Set Bus commands automatically. A transaction is atomic: once a Start completes, the owning channel keeps the engine until its Stop or an error.

## Interface
- NUM_CH, 4: number of requester channels and I2C buses; 2..16.
- DEPTH, 8: per-channel command FIFO depth; power of 2, at least 2.
- LOCK_TIMEOUT, 256: idle-lock timeout in cycles; used only under the macro.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  NUM_CH  per-channel command valid.
- cmd_ready_o  out  NUM_CH  per-channel FIFO not full.
- cmd_op_i  in  3*NUM_CH  opcode, channel c at bits [3c+2:3c]:
  - 100 Start, 101 Stop, 001 Write, 010 Read+ACK, 011 Read+NAK, 111 Wait.
  - 110 (Set Bus) is illegal on this port.
- cmd_data_i  in  8*NUM_CH  write byte, or Wait count.
- eng_valid_o  out  1  command to engine valid.
- eng_ready_i  in  1  engine accepts command.
- eng_op_o  out  3  opcode to engine.
- eng_data_o  out  8  data to engine.
- eng_rsp_valid_i  in  1  engine response strobe.
- eng_rsp_i  in  2  response code: 00 DON, 01 NAK, 10 AL, 11 ERR.
- eng_rsp_data_i  in  8  read byte.
- rsp_valid_o  out  NUM_CH  one-hot response pulse to a channel.
- rsp_code_o  out  2  response code.
- rsp_data_o  out  8  read byte.
- level_o  out  NUM_CH*$clog2(DEPTH+1)  per-channel FIFO occupancy.

## Operation
- FIFOs:
  - Push on cmd_valid_i & cmd_ready_o.
  - cmd_ready_o = !full; no bypass, so a push into a full FIFO is ignored even if a pop occurs that cycle.
  - An illegal opcode 110 is not stored. It is answered with an ERR pulse two cycles later.
- FSM states: IDLE, SETBUS, ISSUE, WAIT_RSP, plus TIMEOUT_STOP under the macro.
- IDLE, grant selection:
  - When locked, only the owner is eligible.
  - Otherwise, round-robin over non-empty FIFOs, searching from last_grant+1. last_grant resets to NUM_CH-1, so channel 0 wins first.
- IDLE, next state:
  - Go to SETBUS if the grant differs from cur_bus; cur_bus resets to invalid.
  - Otherwise go to ISSUE.
- SETBUS:
  - Present op 110 with data = grant index and wait for eng_ready_i.
  - Wait for the response, which is consumed internally.
  - DON: set cur_bus and go to ISSUE.
  - Any other code: pop the head command, send ERR to the grant, set cur_bus invalid, return to IDLE.
- ISSUE: present the FIFO head. On eng_ready_i, pop it and go to WAIT_RSP.
- WAIT_RSP:
  - On eng_rsp_valid_i, register the response to the owner and go to IDLE.
  - eng_rsp_valid_i is ignored in every other state.
- Lock rules:
  - Start+DON sets the lock with owner = grant.
  - Stop with any code clears the lock.
  - AL or ERR clears the lock.
  - NAK keeps the lock; the requester must issue Stop.

## Timing
- Reset values: eng_valid_o=0, eng_op_o=0, eng_data_o=0, rsp_valid_o=0, rsp_code_o=0, rsp_data_o=0, cmd_ready_o=all 1, level_o=0.
- Reset also clears: all FIFOs, lock, cur_bus (to invalid), FSM (to IDLE).
- Reset mid-transaction drops pending commands and produces no response pulses.
- Latency, same bus: push at cycle N into an empty FIFO with the block idle gives eng_valid_o at N+2.
- Latency, bus change: the Set Bus command appears at N+2.
- eng_valid_o, eng_op_o and eng_data_o stay stable until eng_ready_i is sampled high.
- rsp_valid_o pulses exactly one cycle, one cycle after eng_rsp_valid_i.
- At most one command is outstanding at the engine.

## Configuration
- I2CMB_SCHED_LOCK_TIMEOUT_EN defined:
  - A counter runs while the block is locked, in IDLE, with the owner FIFO empty.
  - The counter resets whenever the owner FIFO is non-empty.
  - After LOCK_TIMEOUT cycles, the FSM enters TIMEOUT_STOP and issues Stop on cur_bus.
  - On that Stop's response, the lock is released and an ERR pulse goes to the owner.
- I2CMB_SCHED_LOCK_TIMEOUT_EN undefined: the lock is held indefinitely and LOCK_TIMEOUT is unused.

## Test plan
- Ch0 pushes Start, Write 0x44, Stop; engine returns DON each time:
  - Engine sees Set Bus data 0x00, then Start, Write 0x44, Stop.
  - Ch0 gets three DON pulses.
- Ch1 and ch2 both push Start with the block unlocked and idle: ch1 is granted first. Ch2's Start waits until ch1's Stop completes, then is preceded by Set Bus 0x02.
- Ch3 fills 8 entries: cmd_ready_o[3]=0 and level=8. A 9th push is dropped. After 8 pops the engine has received exactly 8 commands.
- Ch0 Write gets NAK: the lock is kept, and a ch1 Start is held until ch0's Stop.
- Set Bus responds ERR: the head is popped, the grant gets an ERR pulse, and the next command re-issues Set Bus.
- With I2CMB_SCHED_LOCK_TIMEOUT_EN, LOCK_TIMEOUT=16: ch0 Start then idle for 16 cycles. The engine receives Stop, ch0 gets ERR, and the lock is released.

Source files
------------

// File: rtl/i2cmb_cmd_scheduler.sv
// Multi-channel command scheduler: per-channel FIFOs arbitrated onto one I2CMB engine.
// Optional idle-lock timeout enabled by defining I2CMB_SCHED_LOCK_TIMEOUT_EN.
module i2cmb_cmd_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int DEPTH        = 8,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_CH-1:0]                 cmd_valid_i,
  output logic [NUM_CH-1:0]                 cmd_ready_o,
  input  logic [3*NUM_CH-1:0]               cmd_op_i,
  input  logic [8*NUM_CH-1:0]               cmd_data_i,
  output logic                              eng_valid_o,
  input  logic                              eng_ready_i,
  output logic [2:0]                        eng_op_o,
  output logic [7:0]                        eng_data_o,
  input  logic                              eng_rsp_valid_i,
  input  logic [1:0]                        eng_rsp_i,
  input  logic [7:0]                        eng_rsp_data_i,
  output logic [NUM_CH-1:0]                 rsp_valid_o,
  output logic [1:0]                        rsp_code_o,
  output logic [7:0]                        rsp_data_o,
  output logic [NUM_CH*$clog2(DEPTH+1)-1:0] level_o
);

  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  localparam logic [2:0] OP_START  = 3'b100;
  localparam logic [2:0] OP_STOP   = 3'b101;
  localparam logic [2:0] OP_SETBUS = 3'b110;
  localparam logic [1:0] RSP_DON   = 2'b00;
  localparam logic [1:0] RSP_ERR   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETBUS,
    S_ISSUE,
    S_WAIT_RSP
`ifdef I2CMB_SCHED_LOCK_TIMEOUT_EN
    , S_TO_STOP
`endif
  } state_t;

  state_t state_q, state_d;

  logic [10:0]   mem_q [NUM_CH][DEPTH];
  logic [10:0]   mem_d [NUM_CH][DEPTH];
  logic [AW-1:0] wp_q  [NUM_CH];
  logic [AW-1:0] wp_d  [NUM_CH];
  logic [AW-1:0] rp_q  [NUM_CH];
  logic [AW-1:0] rp_d  [NUM_CH];
  logic [LW-1:0] cnt_q [NUM_CH];
  logic [LW-1:0] cnt_d [NUM_CH];

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] ill;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] notfull;

  logic [CW-1:0] grant_q, grant_d;
  logic [CW-1:0] last_q, last_d;
  logic [CW-1:0] bus_q, bus_d;
  logic          bus_vld_q, bus_vld_d;
  logic          lock_q, lock_d;
  logic [CW-1:0] owner_q, owner_d;
  logic          sent_q, sent_d;
  logic [2:0]    iop_q, iop_d;

  logic          sel_vld;
  logic [CW-1:0] sel_ch;
  logic [10:0]   head;

  logic          eng_valid;
  logic [2:0]    eng_op;
  logic [7:0]    eng_data;

  logic          ev;
  logic [CW-1:0] ev_ch;
  logic [1:0]    ev_code;
  logic [7:0]    ev_data;

  logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_code_q, rsp_code_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic [NUM_CH-1:0] ill_q, ill_d;
  logic [NUM_CH-1:0] ill_pend_q, ill_pend_d;
  logic [NUM_CH-1:0] pend;
  logic              picked;

`ifdef I2CMB_SCHED_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT+1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
`endif

  always_comb begin
    push     = '0;
    ill      = '0;
    nonempty = '0;
    notfull  = '0;
    level_o  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      notfull[c]  = (cnt_q[c] != LW'(DEPTH));
      nonempty[c] = (cnt_q[c] != '0);
      level_o[c*LW +: LW] = cnt_q[c];
      if (cmd_valid_i[c] && notfull[c]) begin
        if (cmd_op_i[3*c +: 3] == OP_SETBUS) ill[c] = 1'b1;
        else                                  push[c] = 1'b1;
      end
    end
  end

  assign cmd_ready_o = notfull;

  // Pushes ignore a same-cycle pop: a full FIFO never accepts.
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem_d[c][wp_q[c]] = {cmd_op_i[3*c +: 3], cmd_data_i[8*c +: 8]};
        wp_d[c] = wp_q[c] + 1'b1;
      end
      if (pop[c]) rp_d[c] = rp_q[c] + 1'b1;
      if (push[c] && !pop[c])      cnt_d[c] = cnt_q[c] + 1'b1;
      else if (!push[c] && pop[c]) cnt_d[c] = cnt_q[c] - 1'b1;
    end
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_ch  = owner_q;
    if (lock_q) begin
      sel_vld = nonempty[owner_q];
    end else begin
      for (int i = 1; i <= NUM_CH; i++) begin
        if (!sel_vld && nonempty[(int'(last_q) + i) % NUM_CH]) begin
          sel_vld = 1'b1;
          sel_ch  = CW'((int'(last_q) + i) % NUM_CH);
        end
      end
    end
  end

`ifdef I2CMB_SCHED_LOCK_TIMEOUT_EN
  assign tmo_hit = lock_q && !nonempty[owner_q] &&
                   (tmo_q == TW'(LOCK_TIMEOUT-1));

  always_comb begin
    tmo_d = '0;
    if (state_q == S_IDLE && lock_q && !nonempty[owner_q] && !tmo_hit)
      tmo_d = tmo_q + 1'b1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    bus_d     = bus_q;
    bus_vld_d = bus_vld_q;
    lock_d    = lock_q;
    owner_d   = owner_q;
    sent_d    = sent_q;
    iop_d     = iop_q;
    pop       = '0;
    ev        = 1'b0;
    ev_ch     = grant_q;
    ev_code   = RSP_DON;
    ev_data   = '0;
    eng_valid = 1'b0;
    eng_op    = '0;
    eng_data  = '0;
    head      = mem_q[grant_q][rp_q[grant_q]];
    unique case (state_q)
      S_IDLE: begin
`ifdef I2CMB_SCHED_LOCK_TIMEOUT_EN
        if (tmo_hit) begin
          state_d = S_TO_STOP;
          sent_d  = 1'b0;
        end else
`endif
        if (sel_vld) begin
          grant_d = sel_ch;
          last_d  = sel_ch;
          sent_d  = 1'b0;
          if (bus_vld_q && bus_q == sel_ch) state_d = S_ISSUE;
          else                              state_d = S_SETBUS;
        end
      end
      S_SETBUS: begin
        if (!sent_q) begin
          eng_valid = 1'b1;
          eng_op    = OP_SETBUS;
          eng_data  = 8'(grant_q);
          if (eng_ready_i) sent_d = 1'b1;
        end else if (eng_rsp_valid_i) begin
          if (eng_rsp_i == RSP_DON) begin
            bus_d     = grant_q;
            bus_vld_d = 1'b1;
            state_d   = S_ISSUE;
          end else begin
            pop[grant_q] = 1'b1;
            ev           = 1'b1;
            ev_code      = RSP_ERR;
            bus_vld_d    = 1'b0;
            state_d      = S_IDLE;
          end
        end
      end
      S_ISSUE: begin
        eng_valid = 1'b1;
        eng_op    = head[10:8];
        eng_data  = head[7:0];
        if (eng_ready_i) begin
          pop[grant_q] = 1'b1;
          iop_d        = head[10:8];
          state_d      = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (eng_rsp_valid_i) begin
          ev      = 1'b1;
          ev_code = eng_rsp_i;
          ev_data = eng_rsp_data_i;
          state_d = S_IDLE;
          // NAK leaves the lock; AL/ERR (code bit 1) and Stop release it.
          if (iop_q == OP_STOP || eng_rsp_i[1]) begin
            lock_d = 1'b0;
          end else if (iop_q == OP_START && eng_rsp_i == RSP_DON) begin
            lock_d  = 1'b1;
            owner_d = grant_q;
          end
        end
      end
`ifdef I2CMB_SCHED_LOCK_TIMEOUT_EN
      S_TO_STOP: begin
        if (!sent_q) begin
          eng_valid = 1'b1;
          eng_op    = OP_STOP;
          if (eng_ready_i) sent_d = 1'b1;
        end else if (eng_rsp_valid_i) begin
          lock_d  = 1'b0;
          ev      = 1'b1;
          ev_ch   = owner_q;
          ev_code = RSP_ERR;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign eng_valid_o = eng_valid;
  assign eng_op_o    = eng_op;
  assign eng_data_o  = eng_data;

  // Engine-side responses win; illegal-op ERRs wait in a pending set.
  always_comb begin
    rsp_valid_d = '0;
    rsp_code_d  = rsp_code_q;
    rsp_data_d  = rsp_data_q;
    ill_d       = ill;
    pend        = ill_pend_q | ill_q;
    picked      = 1'b0;
    if (ev) begin
      rsp_valid_d[ev_ch] = 1'b1;
      rsp_code_d         = ev_code;
      rsp_data_d         = ev_data;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!picked && pend[c]) begin
          picked         = 1'b1;
          rsp_valid_d[c] = 1'b1;
          rsp_code_d     = RSP_ERR;
          rsp_data_d     = '0;
          pend[c]        = 1'b0;
        end
      end
    end
    ill_pend_d = pend;
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_code_o  = rsp_code_q;
  assign rsp_data_o  = rsp_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mem_q       <= '{default: '0};
      wp_q        <= '{default: '0};
      rp_q        <= '{default: '0};
      cnt_q       <= '{default: '0};
      grant_q     <= '0;
      last_q      <= CW'(NUM_CH-1);
      bus_q       <= '0;
      bus_vld_q   <= 1'b0;
      lock_q      <= 1'b0;
      owner_q     <= '0;
      sent_q      <= 1'b0;
      iop_q       <= '0;
      rsp_valid_q <= '0;
      rsp_code_q  <= '0;
      rsp_data_q  <= '0;
      ill_q       <= '0;
      ill_pend_q  <= '0;
`ifdef I2CMB_SCHED_LOCK_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      bus_q       <= bus_d;
      bus_vld_q   <= bus_vld_d;
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      sent_q      <= sent_d;
      iop_q       <= iop_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_data_q  <= rsp_data_d;
      ill_q       <= ill_d;
      ill_pend_q  <= ill_pend_d;
`ifdef I2CMB_SCHED_LOCK_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_i2cmb_cmd_scheduler.sv
// Directed testbench for i2cmb_cmd_scheduler (NUM_CH=4, DEPTH=8).
// The timeout scenario runs only when I2CMB_SCHED_LOCK_TIMEOUT_EN is defined.
module tb_i2cmb_cmd_scheduler;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam int LW     = 4;
`ifdef I2CMB_SCHED_LOCK_TIMEOUT_EN
  localparam int LT = 16;
`else
  localparam int LT = 256;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cmd_valid_i = '0;
  logic [3:0]  cmd_ready_o;
  logic [11:0] cmd_op_i = '0;
  logic [31:0] cmd_data_i = '0;
  logic        eng_valid_o;
  logic        eng_ready_i = 1'b0;
  logic [2:0]  eng_op_o;
  logic [7:0]  eng_data_o;
  logic        eng_rsp_valid_i = 1'b0;
  logic [1:0]  eng_rsp_i = '0;
  logic [7:0]  eng_rsp_data_i = '0;
  logic [3:0]  rsp_valid_o;
  logic [1:0]  rsp_code_o;
  logic [7:0]  rsp_data_o;
  logic [15:0] level_o;

  int checks = 0;
  int errors = 0;
  logic [13:0] rq[$];

  i2cmb_cmd_scheduler #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i),
    .eng_valid_o(eng_valid_o), .eng_ready_i(eng_ready_i),
    .eng_op_o(eng_op_o), .eng_data_o(eng_data_o),
    .eng_rsp_valid_i(eng_rsp_valid_i), .eng_rsp_i(eng_rsp_i),
    .eng_rsp_data_i(eng_rsp_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_code_o(rsp_code_o),
    .rsp_data_o(rsp_data_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  // Response log entry: {channel[3:0], code[1:0], data[7:0]}.
  always @(negedge clk) begin
    if (!rst)
      for (int c = 0; c < NUM_CH; c++)
        if (rsp_valid_o[c]) rq.push_back({4'(c), rsp_code_o, rsp_data_o});
  end

  task automatic push(input int ch, input logic [2:0] op, input logic [7:0] d);
    @(negedge clk);
    cmd_valid_i[ch] = 1'b1;
    cmd_op_i[3*ch +: 3] = op;
    cmd_data_i[8*ch +: 8] = d;
    @(posedge clk);
    #1 cmd_valid_i = '0;
  endtask

  task automatic eng_accept(output bit got, output logic [2:0] op,
                            output logic [7:0] d);
    got = 1'b0;
    op = 'x;
    d = 'x;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (eng_valid_o) begin
        got = 1'b1;
        op = eng_op_o;
        d = eng_data_o;
      end
    end
    if (got) begin
      eng_ready_i = 1'b1;
      @(posedge clk);
      #1 eng_ready_i = 1'b0;
    end
  endtask

  task automatic eng_respond(input logic [1:0] code, input logic [7:0] d);
    @(negedge clk);
    eng_rsp_valid_i = 1'b1;
    eng_rsp_i = code;
    eng_rsp_data_i = d;
    @(posedge clk);
    #1 eng_rsp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (eng_valid_o !== 1'b0 || eng_op_o !== 3'b0 || eng_data_o !== 8'h0) begin
      errors++;
      $display("FAIL reset_eng: v=%b op=%b d=%h need 0/000/00",
               eng_valid_o, eng_op_o, eng_data_o);
    end
    checks++;
    if (rsp_valid_o !== 4'h0 || rsp_code_o !== 2'b0 || rsp_data_o !== 8'h0) begin
      errors++;
      $display("FAIL reset_rsp: v=%b c=%b d=%h need 0000/00/00",
               rsp_valid_o, rsp_code_o, rsp_data_o);
    end
    checks++;
    if (cmd_ready_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_ready: got %b need 1111", cmd_ready_o);
    end
    checks++;
    if (level_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_level: got %h need 0000", level_o);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit got;
    logic [2:0] op;
    logic [7:0] d;
    logic [2:0] eop[4];
    logic [7:0] ed[4];
    eop = '{3'b110, 3'b100, 3'b001, 3'b101};
    ed  = '{8'h00, 8'h00, 8'h44, 8'h00};
    rq.delete();
    push(0, 3'b100, 8'h00);
    @(negedge clk);
    checks++;
    if (eng_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_lat_n1: eng_valid %b need 0", eng_valid_o);
    end
    @(negedge clk);
    checks++;
    if (eng_valid_o !== 1'b1 || eng_op_o !== 3'b110 || eng_data_o !== 8'h00) begin
      errors++;
      $display("FAIL basic_lat_n2: v=%b op=%b d=%h need 1/110/00",
               eng_valid_o, eng_op_o, eng_data_o);
    end
    push(0, 3'b001, 8'h44);
    push(0, 3'b101, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (eng_valid_o !== 1'b1 || eng_op_o !== 3'b110 || eng_data_o !== 8'h00) begin
      errors++;
      $display("FAIL basic_stable: v=%b op=%b d=%h need 1/110/00",
               eng_valid_o, eng_op_o, eng_data_o);
    end
    checks++;
    if (level_o[3:0] !== 4'd3) begin
      errors++;
      $display("FAIL basic_level: got %0d need 3", level_o[3:0]);
    end
    for (int i = 0; i < 4; i++) begin
      eng_accept(got, op, d);
      checks++;
      if (!got || op !== eop[i] || d !== ed[i]) begin
        errors++;
        $display("FAIL basic_cmd%0d: got=%0b op=%b d=%h need op=%b d=%h",
                 i, got, op, d, eop[i], ed[i]);
      end
      eng_respond(2'b00, 8'h00);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rq.size() != 3) begin
      errors++;
      $display("FAIL basic_rsp_count: got %0d need 3", rq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rq[i] !== 14'h0000) begin
          errors++;
          $display("FAIL basic_rsp%0d: got %h need 0000", i, rq[i]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    bit got;
    bit busy;
    logic [2:0] op;
    logic [7:0] d;
    logic [2:0] eop[6];
    logic [7:0] ed[6];
    logic [13:0] ex[4];
    eop = '{3'b110, 3'b100, 3'b101, 3'b110, 3'b100, 3'b101};
    ed  = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
    ex  = '{14'h0400, 14'h0400, 14'h0800, 14'h0800};
    rq.delete();
    @(negedge clk);
    cmd_valid_i = 4'b0110;
    cmd_op_i[5:3] = 3'b100;
    cmd_op_i[8:6] = 3'b100;
    @(posedge clk);
    #1 cmd_valid_i = '0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        busy = 1'b0;
        repeat (6) begin
          @(negedge clk);
          if (eng_valid_o) busy = 1'b1;
        end
        checks++;
        if (busy) begin
          errors++;
          $display("FAIL rr_locked_hold: eng_valid seen while ch1 locked, need none");
        end
        push(1, 3'b101, 8'h00);
      end
      if (i == 5) push(2, 3'b101, 8'h00);
      eng_accept(got, op, d);
      checks++;
      if (!got || op !== eop[i] || d !== ed[i]) begin
        errors++;
        $display("FAIL rr_cmd%0d: got=%0b op=%b d=%h need op=%b d=%h",
                 i, got, op, d, eop[i], ed[i]);
      end
      eng_respond(2'b00, 8'h00);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rq.size() != 4) begin
      errors++;
      $display("FAIL rr_rsp_count: got %0d need 4", rq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rq[i] !== ex[i]) begin
          errors++;
          $display("FAIL rr_rsp%0d: got %h need %h", i, rq[i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    bit got;
    bit busy;
    int n;
    logic [2:0] op;
    logic [7:0] d;
    rq.delete();
    for (int i = 0; i < 8; i++) push(3, 3'b001, 8'h30 + 8'(i));
    checks++;
    if (level_o[15:12] !== 4'd8 || cmd_ready_o[3] !== 1'b0) begin
      errors++;
      $display("FAIL full_level: level=%0d ready=%b need 8/0",
               level_o[15:12], cmd_ready_o[3]);
    end
    push(3, 3'b001, 8'hEE);
    checks++;
    if (level_o[15:12] !== 4'd8) begin
      errors++;
      $display("FAIL full_drop: level=%0d need 8", level_o[15:12]);
    end
    eng_accept(got, op, d);
    checks++;
    if (!got || op !== 3'b110 || d !== 8'h03) begin
      errors++;
      $display("FAIL full_setbus: got=%0b op=%b d=%h need 110/03", got, op, d);
    end
    eng_respond(2'b00, 8'h00);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      eng_accept(got, op, d);
      if (got) n++;
      checks++;
      if (!got || op !== 3'b001 || d !== 8'h30 + 8'(i)) begin
        errors++;
        $display("FAIL full_cmd%0d: got=%0b op=%b d=%h need 001/%h",
                 i, got, op, d, 8'h30 + 8'(i));
      end
      eng_respond(2'b00, 8'h00);
    end
    busy = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (eng_valid_o) busy = 1'b1;
    end
    checks++;
    if (busy || n != 8 || level_o[15:12] !== 4'd0) begin
      errors++;
      $display("FAIL full_drain: extra=%0b n=%0d level=%0d need 0/8/0",
               busy, n, level_o[15:12]);
    end
    checks++;
    if (rq.size() != 8 || rq[0] !== 14'h0C00 || rq[7] !== 14'h0C00) begin
      errors++;
      $display("FAIL full_rsp: count=%0d need 8 ch3 DON", rq.size());
    end
  endtask

  task automatic test_nak_lock();
    bit got;
    bit busy;
    logic [2:0] op;
    logic [7:0] d;
    logic [2:0] eop[7];
    logic [7:0] ed[7];
    logic [1:0] rc[7];
    logic [13:0] ex[5];
    eop = '{3'b110, 3'b100, 3'b001, 3'b101, 3'b110, 3'b100, 3'b101};
    ed  = '{8'h00, 8'h00, 8'h55, 8'h00, 8'h01, 8'h00, 8'h00};
    rc  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    ex  = '{14'h0000, 14'h0100, 14'h0000, 14'h0400, 14'h0400};
    rq.delete();
    push(0, 3'b100, 8'h00);
    push(0, 3'b001, 8'h55);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        push(1, 3'b100, 8'h00);
        busy = 1'b0;
        repeat (6) begin
          @(negedge clk);
          if (eng_valid_o) busy = 1'b1;
        end
        checks++;
        if (busy) begin
          errors++;
          $display("FAIL nak_lock_hold: ch1 served while ch0 locked, need none");
        end
        push(0, 3'b101, 8'h00);
      end
      if (i == 6) push(1, 3'b101, 8'h00);
      eng_accept(got, op, d);
      checks++;
      if (!got || op !== eop[i] || d !== ed[i]) begin
        errors++;
        $display("FAIL nak_cmd%0d: got=%0b op=%b d=%h need op=%b d=%h",
                 i, got, op, d, eop[i], ed[i]);
      end
      eng_respond(rc[i], 8'h00);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rq.size() != 5) begin
      errors++;
      $display("FAIL nak_rsp_count: got %0d need 5", rq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rq[i] !== ex[i]) begin
          errors++;
          $display("FAIL nak_rsp%0d: got %h need %h", i, rq[i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_setbus_err();
    bit got;
    logic [2:0] op;
    logic [7:0] d;
    rq.delete();
    push(2, 3'b001, 8'h12);
    eng_accept(got, op, d);
    checks++;
    if (!got || op !== 3'b110 || d !== 8'h02) begin
      errors++;
      $display("FAIL sberr_setbus: got=%0b op=%b d=%h need 110/02", got, op, d);
    end
    eng_respond(2'b11, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (level_o[11:8] !== 4'd0 || rq.size() != 1 || rq[0] !== 14'h0B00) begin
      errors++;
      $display("FAIL sberr_pop: level=%0d rsp_count=%0d need 0 and one ch2 ERR",
               level_o[11:8], rq.size());
    end
    push(2, 3'b010, 8'h00);
    eng_accept(got, op, d);
    checks++;
    if (!got || op !== 3'b110 || d !== 8'h02) begin
      errors++;
      $display("FAIL sberr_reissue: got=%0b op=%b d=%h need 110/02", got, op, d);
    end
    eng_respond(2'b00, 8'h00);
    eng_accept(got, op, d);
    checks++;
    if (!got || op !== 3'b010 || d !== 8'h00) begin
      errors++;
      $display("FAIL sberr_read: got=%0b op=%b d=%h need 010/00", got, op, d);
    end
    eng_respond(2'b00, 8'hC3);
    repeat (2) @(negedge clk);
    checks++;
    if (rq.size() != 2 || rq[1] !== 14'h08C3) begin
      errors++;
      $display("FAIL sberr_read_rsp: count=%0d last=%h need 2/08c3",
               rq.size(), rq[rq.size()-1]);
    end
  endtask

  task automatic test_illegal();
    push(0, 3'b110, 8'h00);
    checks++;
    if (level_o[3:0] !== 4'd0) begin
      errors++;
      $display("FAIL ill_not_stored: level=%0d need 0", level_o[3:0]);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 4'b0000) begin
      errors++;
      $display("FAIL ill_early: rsp_valid=%b need 0000", rsp_valid_o);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 4'b0001 || rsp_code_o !== 2'b11) begin
      errors++;
      $display("FAIL ill_err: rsp_valid=%b code=%b need 0001/11",
               rsp_valid_o, rsp_code_o);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 4'b0000 || eng_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ill_pulse: rsp_valid=%b eng_valid=%b need 0000/0",
               rsp_valid_o, eng_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    bit busy;
    logic [2:0] op;
    logic [7:0] d;
    push(1, 3'b100, 8'h00);
    push(1, 3'b001, 8'h77);
    @(negedge clk);
    rst = 1'b1;
    rq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    busy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (eng_valid_o) busy = 1'b1;
    end
    checks++;
    if (busy || level_o !== 16'h0 || rq.size() != 0) begin
      errors++;
      $display("FAIL rstmid_clear: eng=%0b level=%h rsp_count=%0d need 0/0000/0",
               busy, level_o, rq.size());
    end
    push(2, 3'b001, 8'h99);
    eng_accept(got, op, d);
    checks++;
    if (!got || op !== 3'b110 || d !== 8'h02) begin
      errors++;
      $display("FAIL rstmid_setbus: got=%0b op=%b d=%h need 110/02", got, op, d);
    end
    eng_respond(2'b00, 8'h00);
    eng_accept(got, op, d);
    checks++;
    if (!got || op !== 3'b001 || d !== 8'h99) begin
      errors++;
      $display("FAIL rstmid_write: got=%0b op=%b d=%h need 001/99", got, op, d);
    end
    eng_respond(2'b00, 8'h00);
    repeat (2) @(negedge clk);
  endtask

`ifdef I2CMB_SCHED_LOCK_TIMEOUT_EN
  task automatic test_timeout();
    bit got;
    bit busy;
    logic [2:0] op;
    logic [7:0] d;
    rq.delete();
    push(0, 3'b100, 8'h00);
    eng_accept(got, op, d);
    eng_respond(2'b00, 8'h00);
    eng_accept(got, op, d);
    checks++;
    if (!got || op !== 3'b100) begin
      errors++;
      $display("FAIL tmo_start: got=%0b op=%b need 100", got, op);
    end
    eng_respond(2'b00, 8'h00);
    busy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (eng_valid_o) busy = 1'b1;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL tmo_early: engine command before timeout, need none");
    end
    eng_accept(got, op, d);
    checks++;
    if (!got || op !== 3'b101) begin
      errors++;
      $display("FAIL tmo_stop: got=%0b op=%b need 101", got, op);
    end
    eng_respond(2'b00, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (rq.size() != 2 || rq[1] !== 14'h0300) begin
      errors++;
      $display("FAIL tmo_err: count=%0d need 2 ending ch0 ERR", rq.size());
    end
    push(1, 3'b001, 8'h00);
    eng_accept(got, op, d);
    checks++;
    if (!got || op !== 3'b110 || d !== 8'h01) begin
      errors++;
      $display("FAIL tmo_unlock: got=%0b op=%b d=%h need 110/01", got, op, d);
    end
    eng_respond(2'b00, 8'h00);
    eng_accept(got, op, d);
    eng_respond(2'b00, 8'h00);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_fifo_full();
    test_nak_lock();
    test_setbus_err();
    test_illegal();
    test_reset_mid();
`ifdef I2CMB_SCHED_LOCK_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
